// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : add_seq_ctrl
// Purpose : Wide unsigned adder sequenced one nibble per cycle through an
//           external 4-bit ripple adder. Optional macro: ADD_SEQ_OVF_EN (ovf).
// Revision: 1.0
// ============================================================================
module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
`ifdef ADD_SEQ_OVF_EN
    output logic                   ovf,
`endif
    output logic [3:0]             fa_a,
    output logic [3:0]             fa_b,
    output logic                   fa_cin,
    input  logic [3:0]             fa_sum,
    input  logic                   fa_cout
);

    localparam int                c_W    = 4 * NIBBLES;
    localparam int                c_IW   = $clog2(NIBBLES);
    localparam logic [c_IW-1:0]   c_LAST = c_IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic              r_carry;
    logic [c_IW-1:0]   r_idx;
    logic [c_IW+1:0]   w_lsb;
    logic              w_run;

    assign w_lsb = {r_idx, 2'b00};
    assign w_run = (r_state == S_RUN);

    // Adder inputs come straight from registers and are forced to zero outside RUN.
    always_comb begin
        fa_a   = 4'd0;
        fa_b   = 4'd0;
        fa_cin = 1'b0;
        if (w_run) begin
            fa_a   = r_a[w_lsb +: 4];
            fa_b   = r_b[w_lsb +: 4];
            fa_cin = r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef ADD_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
`ifdef ADD_SEQ_OVF_EN
                        ovf     <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    sum[w_lsb +: 4] <= fa_sum;
                    r_carry         <= fa_cout;
                    // Index saturates at the last slice so it stays in range for any NIBBLES.
                    if (r_idx == c_LAST) begin
                        cout    <= fa_cout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
`ifdef ADD_SEQ_OVF_EN
                        ovf     <= (r_a[c_W-1] == r_b[c_W-1]) && (fa_sum[3] != r_a[c_W-1]);
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_seq_ctrl
// Purpose : Directed bench for add_seq_ctrl with an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_add_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [W-1:0]   sum;
    logic           cout;
    logic [3:0]     fa_a;
    logic [3:0]     fa_b;
    logic           fa_cin;
    logic [3:0]     fa_sum;
    logic           fa_cout;
`ifdef ADD_SEQ_OVF_EN
    logic           ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // External 4-bit ripple adder stand-in.
    logic [4:0] w_add;
    assign w_add   = {1'b0, fa_a} + {1'b0, fa_b} + {4'd0, fa_cin};
    assign fa_sum  = w_add[3:0];
    assign fa_cout = w_add[4];

    add_seq_ctrl #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
`ifdef ADD_SEQ_OVF_EN
        .ovf     (ovf),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..N processing slice phase-1, N+1 done.
    int           m_phase = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic         m_cin = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        longint unsigned full;
        full = longint'(m_a) + longint'(m_b) + longint'(m_cin);
        if (!rst_n) begin
            m_phase <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_a     <= a;
                m_b     <= b;
                m_cin   <= cin;
                m_sum   <= '0;
                m_cout  <= 1'b0;
                m_ovf   <= 1'b0;
            end
        end else if (m_phase == N) begin
            m_phase <= N + 1;
            m_sum   <= W'(full);
            m_cout  <= full[W];
            m_ovf   <= (m_a[W-1] == m_b[W-1]) && (full[W-1] != m_a[W-1]);
        end else if (m_phase == N + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        longint unsigned la, lb, mask, full;
        int              k;
        logic            e_busy, e_done, e_cout, e_fcin;
        logic [W-1:0]    e_sum;
        logic [3:0]      e_fa, e_fb;
        if (chk_en) begin
            la     = longint'(m_a);
            lb     = longint'(m_b);
            full   = la + lb + longint'(m_cin);
            e_busy = 1'b0;
            e_done = 1'b0;
            e_sum  = m_sum;
            e_cout = m_cout;
            e_fa   = 4'd0;
            e_fb   = 4'd0;
            e_fcin = 1'b0;
            if (m_phase >= 1 && m_phase <= N) begin
                k      = m_phase - 1;
                mask   = (64'd1 << (4 * k)) - 64'd1;
                e_busy = 1'b1;
                e_sum  = W'(full & mask);
                e_cout = 1'b0;
                e_fa   = 4'((la >> (4 * k)) & 64'hF);
                e_fb   = 4'((lb >> (4 * k)) & 64'hF);
                e_fcin = 1'(((la & mask) + (lb & mask) + longint'(m_cin)) >> (4 * k));
            end else if (m_phase == N + 1) begin
                e_done = 1'b1;
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("sum", 64'(sum), 64'(e_sum));
            chk("cout", 64'(cout), 64'(e_cout));
            chk("fa_a", 64'(fa_a), 64'(e_fa));
            chk("fa_b", 64'(fa_b), 64'(e_fb));
            chk("fa_cin", 64'(fa_cin), 64'(e_fcin));
`ifdef ADD_SEQ_OVF_EN
            chk("ovf", 64'(ovf), 64'(m_phase == N + 1 || m_phase == 0 ? m_ovf : 1'b0));
`endif
            if (done) done_cnt++;
        end
    end

    // Presents one request; returns #1 after the accepting edge with start low.
    task automatic do_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] es, input logic ec);
        int lat;
        do_start(va, vb, vc);
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'(N + 1));
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int d0;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h4321;
        cin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'h0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        run_op("basic", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("alt", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1);
        run_op("mix", 16'h8421, 16'h9999, 1'b1, 16'h1DBB, 1'b1);

        // Start held with junk operands through RUN and DONE must be ignored.
        d0 = done_cnt;
        do_start(16'h1234, 16'h1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a     = 16'hFFFF;
            b     = 16'hFFFF;
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("busy_sum", 64'(sum), 64'h2345);
        chk("busy_cout", 64'(cout), 64'd0);
        chk("busy_done_cnt", 64'(done_cnt - d0), 64'd1);
        do_start(16'h0102, 16'h0304, 1'b0);
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'(N + 1));
        chk("b2b_sum", 64'(sum), 64'h0406);
        @(posedge clk); #1;

        // Reset sampled at the second RUN edge aborts without a done pulse.
        d0 = done_cnt;
        do_start(16'h00FF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

`ifdef ADD_SEQ_OVF_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        chk("ovf_pos_flag", 64'(ovf), 64'd1);
        run_op("ovf_neg", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        chk("ovf_neg_flag", 64'(ovf), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
